// File: rtl/ov5640_sccb_responder.sv
// SCCB target emulating the OV5640 register port: decodes 16-bit-address writes and serves register reads.
// Latency: bus edges are acted on SYNC_STAGES+1 clocks after the pin changes; the write strobe fires 1 clock after the 8th data bit's rise.
// Backpressure: none; write strobes are fire-and-forget, and read data must be valid combinationally from reg_rd_addr_o.
module ov5640_sccb_responder #(
  parameter logic [6:0] DEVICE_ADDR = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sccb_scl_i,
  input  logic        sccb_sda_i,
  output logic        sccb_sda_oe_o,
  output logic        reg_wr_valid_o,
  output logic [15:0] reg_wr_addr_o,
  output logic [7:0]  reg_wr_data_o,
  output logic [15:0] reg_rd_addr_o,
  input  logic [7:0]  reg_rd_data_i,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, ADDR_HI, ADDR_HI_ACK, ADDR_LO, ADDR_LO_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_d, sda_d;
  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [1:0]  ack_ph;    // 0: wait fall after 8th bit, 1: wait 9th rise, 2: wait fall ending ack
  logic [7:0]  shreg;
  logic [7:0]  rx_byte;
  logic        rw;
  logic [15:0] pointer;
  logic        sda_oe;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Synchronize the bus lines and keep a one-cycle-delayed copy for edge detection; reset to the idle-bus level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], sccb_scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sccb_sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // START/STOP need SCL stable high across the sample pair; an SDA change coinciding with an SCL edge counts as data
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = ~sda_s & sda_d & scl_s & scl_d;
  assign stop_det  = sda_s & ~sda_d & scl_s & scl_d;
  assign rx_byte   = {shreg[6:0], sda_s};

  // Protocol FSM: byte shifting, ACK driving, pointer management and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      ack_ph   <= 2'd0;
      shreg    <= 8'd0;
      rw       <= 1'b0;
      pointer  <= 16'd0;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 16'd0;
      wr_data  <= 8'd0;
      busy     <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      if (start_det) begin
        state   <= DEV_ADDR;
        bit_cnt <= 3'd0;
        ack_ph  <= 2'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          DEV_ADDR, ADDR_HI, ADDR_LO, WR_DATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_ph <= 2'd0;
                case (state)
                  DEV_ADDR: begin
                    if (rx_byte[7:1] == DEVICE_ADDR) begin
                      busy  <= 1'b1;
                      rw    <= rx_byte[0];
                      state <= DEV_ACK;
                    end else begin
                      state <= IGNORE;
                    end
                  end
                  ADDR_HI: begin
                    pointer[15:8] <= rx_byte;
                    state         <= ADDR_HI_ACK;
                  end
                  ADDR_LO: begin
                    pointer[7:0] <= rx_byte;
                    state        <= ADDR_LO_ACK;
                  end
                  default: begin
                    wr_valid <= 1'b1;
                    wr_addr  <= pointer;
                    wr_data  <= rx_byte;
                    pointer  <= pointer + 16'd1;
                    state    <= WR_ACK;
                  end
                endcase
              end
            end
          end
          DEV_ACK, ADDR_HI_ACK, ADDR_LO_ACK, WR_ACK: begin
            if (ack_ph == 2'd0 && scl_fall) begin
              sda_oe <= 1'b1;
              ack_ph <= 2'd1;
            end else if (ack_ph == 2'd1 && scl_rise) begin
              ack_ph <= 2'd2;
            end else if (ack_ph == 2'd2 && scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              ack_ph  <= 2'd0;
              case (state)
                DEV_ACK: begin
                  if (rw) begin
                    // First read byte is fetched at the falling edge that ends the address ACK
                    state   <= RD_DATA;
                    shreg   <= {reg_rd_data_i[6:0], 1'b0};
                    sda_oe  <= ~reg_rd_data_i[7];
                    pointer <= pointer + 16'd1;
                  end else begin
                    state <= ADDR_HI;
                  end
                end
                ADDR_HI_ACK: state <= ADDR_LO;
                default:     state <= WR_DATA;
              endcase
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              if (bit_cnt == 3'd7) begin
                bit_cnt <= 3'd0;
                ack_ph  <= 2'd0;
                state   <= RD_ACK;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else if (scl_fall) begin
              sda_oe <= ~shreg[7];
              shreg  <= {shreg[6:0], 1'b0};
            end
          end
          RD_ACK: begin
            if (ack_ph == 2'd0 && scl_fall) begin
              sda_oe <= 1'b0;
              ack_ph <= 2'd1;
            end else if (ack_ph == 2'd1 && scl_rise) begin
              // SDA high at the 9th rise is the master's NACK: stop sourcing data
              if (sda_s) state <= IGNORE;
              else       ack_ph <= 2'd2;
            end else if (ack_ph == 2'd2 && scl_fall) begin
              state   <= RD_DATA;
              bit_cnt <= 3'd0;
              ack_ph  <= 2'd0;
              shreg   <= {reg_rd_data_i[6:0], 1'b0};
              sda_oe  <= ~reg_rd_data_i[7];
              pointer <= pointer + 16'd1;
            end
          end
          IGNORE: sda_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign sccb_sda_oe_o  = sda_oe;
  assign reg_wr_valid_o = wr_valid;
  assign reg_wr_addr_o  = wr_addr;
  assign reg_wr_data_o  = wr_data;
  assign reg_rd_addr_o  = pointer;
  assign busy_o         = busy;

endmodule
